// File: rtl/huffman_pkg.sv
// Shared types and defaults for the Huffman tree builder.
// Holds the FSM state enum, the default-width node record and the node index width helper.
package huffman_pkg;

  localparam int DEF_N_SYM  = 6;
  localparam int DEF_FREQ_W = 32;
  localparam int DEF_SYM_W  = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MERGE,
    EMIT,
    DONE
  } state_t;

  typedef struct packed {
    logic [DEF_SYM_W-1:0]  sym;
    logic [DEF_FREQ_W-1:0] freq;
    logic                  active;
  } node_t;

  // Leaves plus internal nodes of a full binary tree: 2*N-1 entries.
  function automatic int nodeWidth(input int nSym);
    return $clog2(2 * nSym - 1);
  endfunction

endpackage

// File: rtl/huffman_min2.sv
// Combinational selector of the two smallest active frequencies.
// Ordering is by (frequency, index), so equal frequencies resolve to the lower node index.
module huffman_min2 #(
  parameter int N      = 11,
  parameter int FREQ_W = 32,
  parameter int IDX_W  = 4
) (
  input  logic [N*FREQ_W-1:0] i_freq,
  input  logic [N-1:0]        i_active,
  output logic [IDX_W-1:0]    o_minIdx,
  output logic [IDX_W-1:0]    o_secIdx
);

  logic [FREQ_W-1:0] w_bestFreq;
  logic [FREQ_W-1:0] w_secFreq;
  logic [FREQ_W-1:0] w_curFreq;
  logic              w_haveBest;
  logic              w_haveSec;

  // Ascending scan with strict compares keeps the earlier index on ties.
  always_comb begin
    o_minIdx   = '0;
    o_secIdx   = '0;
    w_bestFreq = '0;
    w_secFreq  = '0;
    w_curFreq  = '0;
    w_haveBest = 1'b0;
    w_haveSec  = 1'b0;
    for (int i = 0; i < N; i++) begin
      w_curFreq = i_freq[i*FREQ_W +: FREQ_W];
      if (i_active[i]) begin
        if (!w_haveBest || (w_curFreq < w_bestFreq)) begin
          o_secIdx   = o_minIdx;
          w_secFreq  = w_bestFreq;
          w_haveSec  = w_haveBest;
          o_minIdx   = IDX_W'(i);
          w_bestFreq = w_curFreq;
          w_haveBest = 1'b1;
        end else if (!w_haveSec || (w_curFreq < w_secFreq)) begin
          o_secIdx  = IDX_W'(i);
          w_secFreq = w_curFreq;
          w_haveSec = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/huffman_tree_builder.sv
// Builds a Huffman tree from loaded leaves, streaming one merge record per step.
// Leaves occupy nodes 0..N_SYM-1; parents are allocated from N_SYM upward.
module huffman_tree_builder
  import huffman_pkg::*;
#(
  parameter int N_SYM  = DEF_N_SYM,
  parameter int FREQ_W = DEF_FREQ_W,
  parameter int SYM_W  = DEF_SYM_W,
  localparam int NODE_W = nodeWidth(N_SYM)
) (
  input  logic              i_clk,
  input  logic              i_ctrl_reset,
  input  logic              i_ld_valid,
  output logic              o_ld_ready,
  input  logic [SYM_W-1:0]  i_ld_sym,
  input  logic [FREQ_W-1:0] i_ld_freq,
  input  logic              i_ctrl_start,
  output logic              o_busy,
  output logic              o_out_valid,
  input  logic              i_out_ready,
  output logic [NODE_W-1:0] o_out_left,
  output logic [NODE_W-1:0] o_out_right,
  output logic [NODE_W-1:0] o_out_parent,
  output logic [FREQ_W-1:0] o_out_freq,
  output logic              o_done,
  output logic [NODE_W-1:0] o_root_idx,
  output logic              o_ovf
);

  localparam int N_NODE = 2 * N_SYM - 1;
  localparam int CNT_W  = $clog2(N_SYM + 1);

  typedef struct packed {
    logic [SYM_W-1:0]  sym;
    logic [FREQ_W-1:0] freq;
    logic              active;
  } nodeRec_t;

  state_t              r_state;
  state_t              w_nextState;
  nodeRec_t            r_node [N_NODE];
  logic [CNT_W-1:0]    r_leafCount;
  logic [NODE_W-1:0]   r_mergeCount;
  logic [NODE_W-1:0]   r_rootIdx;
  logic [NODE_W-1:0]   r_outLeft;
  logic [NODE_W-1:0]   r_outRight;
  logic [NODE_W-1:0]   r_outParent;
  logic [FREQ_W-1:0]   r_outFreq;
  logic                r_ovf;

  logic [N_NODE*FREQ_W-1:0] w_freqFlat;
  logic [N_NODE-1:0]        w_activeVec;
  logic [NODE_W-1:0]        w_leftIdx;
  logic [NODE_W-1:0]        w_rightIdx;
  logic [NODE_W-1:0]        w_parentIdx;
  logic [NODE_W-1:0]        w_leafIdx;
  logic [FREQ_W:0]          w_sum;
  logic [FREQ_W-1:0]        w_sumSat;
  logic                     w_idleOrLoad;
  logic                     w_startAccept;
  logic                     w_loadAccept;
  logic                     w_lastMerge;

  for (genvar g = 0; g < N_NODE; g++) begin : g_flat
    assign w_freqFlat[g*FREQ_W +: FREQ_W] = r_node[g].freq;
    assign w_activeVec[g]                 = r_node[g].active;
  end

  huffman_min2 #(
    .N      (N_NODE),
    .FREQ_W (FREQ_W),
    .IDX_W  (NODE_W)
  ) u_min2 (
    .i_freq   (w_freqFlat),
    .i_active (w_activeVec),
    .o_minIdx (w_leftIdx),
    .o_secIdx (w_rightIdx)
  );

  // A start and a load in the same cycle resolve in favour of the start.
  assign w_idleOrLoad  = (r_state == IDLE) || (r_state == LOAD);
  assign w_startAccept = i_ctrl_start && w_idleOrLoad;
  assign o_ld_ready    = w_idleOrLoad && (r_leafCount < CNT_W'(N_SYM)) && !i_ctrl_start;
  assign w_loadAccept  = i_ld_valid && o_ld_ready;

  assign w_leafIdx   = NODE_W'(r_leafCount);
  assign w_parentIdx = NODE_W'(N_SYM) + r_mergeCount;
  assign w_sum       = {1'b0, r_node[w_leftIdx].freq} + {1'b0, r_node[w_rightIdx].freq};
  assign w_sumSat    = w_sum[FREQ_W] ? '1 : w_sum[FREQ_W-1:0];
  assign w_lastMerge = (r_mergeCount + NODE_W'(1)) == (NODE_W'(r_leafCount) - NODE_W'(1));

  assign o_busy       = (r_state == MERGE) || (r_state == EMIT);
  assign o_out_valid  = (r_state == EMIT);
  assign o_done       = (r_state == DONE);
  assign o_out_left   = r_outLeft;
  assign o_out_right  = r_outRight;
  assign o_out_parent = r_outParent;
  assign o_out_freq   = r_outFreq;
  assign o_root_idx   = r_rootIdx;
  assign o_ovf        = r_ovf;

  always_ff @(posedge i_clk) begin
    if (i_ctrl_reset) r_state <= IDLE;
    else              r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE:    if (w_startAccept) w_nextState = DONE;
               else if (w_loadAccept) w_nextState = LOAD;
      LOAD:    if (w_startAccept) w_nextState = (r_leafCount >= CNT_W'(2)) ? MERGE : DONE;
      MERGE:   w_nextState = EMIT;
      EMIT:    if (i_out_ready) w_nextState = w_lastMerge ? DONE : MERGE;
      DONE:    w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // Node table, counters and the registered merge record.
  always_ff @(posedge i_clk) begin
    if (i_ctrl_reset) begin
      r_leafCount  <= '0;
      r_mergeCount <= '0;
      r_rootIdx    <= '0;
      r_outLeft    <= '0;
      r_outRight   <= '0;
      r_outParent  <= '0;
      r_outFreq    <= '0;
      r_ovf        <= 1'b0;
      for (int i = 0; i < N_NODE; i++) r_node[i] <= '0;
    end else begin
      case (r_state)
        IDLE, LOAD: begin
          if (w_startAccept) begin
            r_rootIdx <= '0;
            r_ovf     <= 1'b0;
          end else if (w_loadAccept) begin
            r_node[w_leafIdx] <= {i_ld_sym, i_ld_freq, 1'b1};
            r_leafCount       <= r_leafCount + CNT_W'(1);
          end
        end
        MERGE: begin
          r_outLeft                 <= w_leftIdx;
          r_outRight                <= w_rightIdx;
          r_outParent               <= w_parentIdx;
          r_outFreq                 <= w_sumSat;
          r_node[w_leftIdx].active  <= 1'b0;
          r_node[w_rightIdx].active <= 1'b0;
          r_node[w_parentIdx]       <= {SYM_W'(0), w_sumSat, 1'b1};
          if (w_sum[FREQ_W]) r_ovf <= 1'b1;
        end
        EMIT: begin
          if (i_out_ready) begin
            r_mergeCount <= r_mergeCount + NODE_W'(1);
            if (w_lastMerge) r_rootIdx <= r_outParent;
          end
        end
        DONE: begin
          r_leafCount  <= '0;
          r_mergeCount <= '0;
          for (int i = 0; i < N_NODE; i++) r_node[i].active <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_huffman_tree_builder.sv
// Directed bench for the Huffman tree builder: a 32-bit and an 8-bit frequency instance
// share all stimulus so saturation can be observed alongside the wide reference.
module tb_huffman_tree_builder;

  localparam int N_SYM  = 6;
  localparam int NODE_W = 4;

  logic        clk = 1'b0;
  logic        ctrlReset;
  logic        ldValid;
  logic        ctrlStart;
  logic        outReady;
  logic [7:0]  ldSym;
  logic [31:0] ldFreq;
  logic [7:0]  ldFreq8;

  logic              ldReady, busy, outValid, done, ovf;
  logic [NODE_W-1:0] outLeft, outRight, outParent, rootIdx;
  logic [31:0]       outFreq;

  logic              ldReady8, busy8, outValid8, done8, ovf8;
  logic [NODE_W-1:0] outLeft8, outRight8, outParent8, rootIdx8;
  logic [7:0]        outFreq8;

  int checks = 0;
  int errors = 0;
  int loadFreq [8];
  int expL [5];
  int expR [5];
  int expP [5];
  int expF [5];

  always #5 clk = ~clk;
  assign ldFreq8 = ldFreq[7:0];

  huffman_tree_builder #(.N_SYM(N_SYM), .FREQ_W(32), .SYM_W(8)) dut (
    .i_clk(clk), .i_ctrl_reset(ctrlReset),
    .i_ld_valid(ldValid), .o_ld_ready(ldReady), .i_ld_sym(ldSym), .i_ld_freq(ldFreq),
    .i_ctrl_start(ctrlStart), .o_busy(busy),
    .o_out_valid(outValid), .i_out_ready(outReady),
    .o_out_left(outLeft), .o_out_right(outRight), .o_out_parent(outParent), .o_out_freq(outFreq),
    .o_done(done), .o_root_idx(rootIdx), .o_ovf(ovf)
  );

  huffman_tree_builder #(.N_SYM(N_SYM), .FREQ_W(8), .SYM_W(8)) dut8 (
    .i_clk(clk), .i_ctrl_reset(ctrlReset),
    .i_ld_valid(ldValid), .o_ld_ready(ldReady8), .i_ld_sym(ldSym), .i_ld_freq(ldFreq8),
    .i_ctrl_start(ctrlStart), .o_busy(busy8),
    .o_out_valid(outValid8), .i_out_ready(outReady),
    .o_out_left(outLeft8), .o_out_right(outRight8), .o_out_parent(outParent8), .o_out_freq(outFreq8),
    .o_done(done8), .o_root_idx(rootIdx8), .o_ovf(ovf8)
  );

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Offers one load beat from a negedge; reports whether ready was high.
  task automatic applyStimulus(input logic [7:0] sym, input logic [31:0] freq, output bit accepted);
    ldValid = 1'b1;
    ldSym   = sym;
    ldFreq  = freq;
    #1 accepted = ldReady;
    @(negedge clk);
    ldValid = 1'b0;
  endtask

  task automatic loadLeaves(input int n);
    bit acc;
    for (int i = 0; i < n; i++) begin
      applyStimulus(8'(8'h41 + i), 32'(loadFreq[i]), acc);
      checkOutput($sformatf("ldAccept%0d", i), 64'(acc), 64'(i < N_SYM));
    end
  endtask

  task automatic startPulse();
    ctrlStart = 1'b1;
    @(negedge clk);
    ctrlStart = 1'b0;
  endtask

  task automatic setRecord(input int k, input int l, input int r, input int p, input int f);
    expL[k] = l;
    expR[k] = r;
    expP[k] = p;
    expF[k] = f;
  endtask

  // Follows a build from MERGE entry; abortAt >= 0 returns with that record on the bus.
  task automatic runBuild(input int nRec, input int stall, input int abortAt, input int expRoot);
    int  k        = 0;
    int  stallCnt = 0;
    int  cycles   = 0;
    bit  seenDone = 1'b0;
    for (int c = 0; c < 200 && !seenDone; c++) begin
      if (outValid) begin
        if (k < 5) begin
          checkOutput($sformatf("rec%0d.left", k),   64'(outLeft),   64'(expL[k]));
          checkOutput($sformatf("rec%0d.right", k),  64'(outRight),  64'(expR[k]));
          checkOutput($sformatf("rec%0d.parent", k), 64'(outParent), 64'(expP[k]));
          checkOutput($sformatf("rec%0d.freq", k),   64'(outFreq),   64'(expF[k]));
        end else begin
          checkOutput("recordOverrun", 64'(k), 64'(nRec));
        end
        if (k == abortAt) begin
          outReady = 1'b0;
          return;
        end
        if (k == 0 && stallCnt < stall) begin
          outReady = 1'b0;
          stallCnt++;
        end else begin
          outReady = 1'b1;
          k++;
        end
      end else begin
        outReady = 1'b1;
      end
      if (done) begin
        seenDone = 1'b1;
        checkOutput("recordCount", 64'(k), 64'(nRec));
        checkOutput("latency", 64'(cycles), 64'(2 * nRec + stall));
        checkOutput("rootIdx", 64'(rootIdx), 64'(expRoot));
        checkOutput("busyAtDone", 64'(busy), 64'(0));
      end else begin
        @(negedge clk);
        cycles++;
      end
    end
    if (!seenDone) checkOutput("doneTimeout", 64'(0), 64'(1));
    outReady = 1'b1;
    @(negedge clk);
  endtask

  task automatic setReferenceTree();
    loadFreq = '{5, 9, 12, 13, 16, 45, 1, 0};
    setRecord(0, 0, 1, 6, 14);
    setRecord(1, 2, 3, 7, 25);
    setRecord(2, 6, 4, 8, 30);
    setRecord(3, 7, 8, 9, 55);
    setRecord(4, 5, 9, 10, 100);
  endtask

  task automatic setTieTree();
    loadFreq = '{3, 3, 3, 0, 0, 0, 0, 0};
    setRecord(0, 0, 1, 6, 6);
    setRecord(1, 2, 6, 7, 9);
  endtask

  initial begin
    ctrlReset = 1'b1;
    ldValid   = 1'b0;
    ctrlStart = 1'b0;
    outReady  = 1'b1;
    ldSym     = '0;
    ldFreq    = '0;
    repeat (2) @(negedge clk);
    ctrlReset = 1'b0;

    checkOutput("rst.outValid", 64'(outValid), 64'(0));
    checkOutput("rst.busy",     64'(busy),     64'(0));
    checkOutput("rst.done",     64'(done),     64'(0));
    checkOutput("rst.ovf",      64'(ovf),      64'(0));
    checkOutput("rst.rootIdx",  64'(rootIdx),  64'(0));
    checkOutput("rst.outLeft",  64'(outLeft),  64'(0));
    checkOutput("rst.outFreq",  64'(outFreq),  64'(0));
    checkOutput("rst.ldReady",  64'(ldReady),  64'(1));

    // Seven beats into six slots; the refused seventh must not disturb the tree.
    setReferenceTree();
    loadLeaves(7);
    startPulse();
    checkOutput("busyAfterStart", 64'(busy), 64'(1));
    runBuild(5, 0, -1, 10);
    checkOutput("rootHold", 64'(rootIdx), 64'(10));
    checkOutput("ovfRef",   64'(ovf),     64'(0));

    // Backpressure on the first record with start held high throughout.
    loadLeaves(6);
    startPulse();
    ctrlStart = 1'b1;
    runBuild(5, 5, -1, 10);
    ctrlStart = 1'b0;
    checkOutput("rootAfterBusyStart", 64'(rootIdx), 64'(10));

    setTieTree();
    loadLeaves(3);
    startPulse();
    runBuild(2, 0, -1, 7);

    loadFreq = '{200, 100, 0, 0, 0, 0, 0, 0};
    setRecord(0, 1, 0, 6, 300);
    loadLeaves(2);
    startPulse();
    runBuild(1, 0, -1, 6);
    checkOutput("wide.ovf",      64'(ovf),        64'(0));
    checkOutput("sat.left",      64'(outLeft8),   64'(1));
    checkOutput("sat.right",     64'(outRight8),  64'(0));
    checkOutput("sat.parent",    64'(outParent8), 64'(6));
    checkOutput("sat.freq",      64'(outFreq8),   64'(255));
    checkOutput("sat.ovf",       64'(ovf8),       64'(1));
    checkOutput("sat.rootIdx",   64'(rootIdx8),   64'(6));
    checkOutput("sat.busy",      64'(busy8),      64'(0));
    checkOutput("sat.outValid",  64'(outValid8),  64'(0));
    checkOutput("sat.done",      64'(done8),      64'(0));
    checkOutput("sat.ldReady",   64'(ldReady8),   64'(1));

    loadFreq = '{7, 0, 0, 0, 0, 0, 0, 0};
    loadLeaves(1);
    startPulse();
    runBuild(0, 0, -1, 0);
    checkOutput("sat.ovfCleared", 64'(ovf8), 64'(0));

    startPulse();
    runBuild(0, 0, -1, 0);

    // Reset while the third record is offered, racing a start and a load beat.
    setReferenceTree();
    loadLeaves(6);
    startPulse();
    runBuild(5, 0, 2, 0);
    ctrlReset = 1'b1;
    ldValid   = 1'b1;
    ldFreq    = 32'd1;
    ctrlStart = 1'b1;
    @(negedge clk);
    checkOutput("abort.outValid",  64'(outValid),  64'(0));
    checkOutput("abort.busy",      64'(busy),      64'(0));
    checkOutput("abort.done",      64'(done),      64'(0));
    checkOutput("abort.outLeft",   64'(outLeft),   64'(0));
    checkOutput("abort.outParent", 64'(outParent), 64'(0));
    checkOutput("abort.outFreq",   64'(outFreq),   64'(0));
    checkOutput("abort.rootIdx",   64'(rootIdx),   64'(0));
    ctrlReset = 1'b0;
    ldValid   = 1'b0;
    ctrlStart = 1'b0;
    outReady  = 1'b1;
    setTieTree();
    loadLeaves(3);
    startPulse();
    runBuild(2, 0, -1, 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
